// File: rtl/sram_if.sv
// Read/write port bundle for the sram macro model: one read port and one
// granule-enabled write port sharing the macro's clock.
interface sram_if #(
    parameter int WIDTH    = 64,
    parameter int LOGDEPTH = 9,
    parameter int WORDSIZE = 64
);
    localparam int NWE = WIDTH / WORDSIZE;

    logic [LOGDEPTH-1:0] readAddr;
    logic [WIDTH-1:0]    readData;
    logic [LOGDEPTH-1:0] writeAddr;
    logic [WIDTH-1:0]    writeData;
    logic [NWE-1:0]      writeEnable;

    modport master (
        output readAddr,
        output writeAddr,
        output writeData,
        output writeEnable,
        input  readData
    );

    modport slave (
        input  readAddr,
        input  writeAddr,
        input  writeData,
        input  writeEnable,
        output readData
    );
endinterface

// File: rtl/sram.sv
// Synchronous 1R/1W SRAM with per-granule write enables and a registered,
// optionally deeper, read pipeline. Define SRAM_WR_BYPASS_EN for write-first per granule.
module sram #(
    parameter int WIDTH    = 64,
    parameter int LOGDEPTH = 9,
    parameter int WORDSIZE = 64,
    parameter int DELAY    = ((LOGDEPTH > 32'sd8) ? (LOGDEPTH - 32'sd8) : 32'sd1) - 32'sd1
) (
    input logic   clk,
    input logic   reset_n,
    sram_if.slave bus
);
    localparam int NWE   = WIDTH / WORDSIZE;
    localparam int DEPTH = 32'sd1 << LOGDEPTH;

    if ((WIDTH % WORDSIZE) != 32'sd0) begin : g_width_check
        $fatal(1, "sram: WIDTH must be an integer multiple of WORDSIZE");
    end

    logic [WIDTH-1:0] mem_q  [DEPTH];
    logic [WIDTH-1:0] pipe_q [DELAY+1];
    logic [WIDTH-1:0] pipe_d [DELAY+1];
    logic [WIDTH-1:0] cap_s;

    // Array write: enabled granules of the addressed row take the new data.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int g = 0; g < NWE; g++) begin
                if (bus.writeEnable[g]) begin
                    mem_q[bus.writeAddr][g*WORDSIZE +: WORDSIZE] <= bus.writeData[g*WORDSIZE +: WORDSIZE];
                end
            end
        end
    end

    // First-stage capture; read-first unless the bypass overlays fresh granules.
    always_comb begin
        cap_s = mem_q[bus.readAddr];
`ifdef SRAM_WR_BYPASS_EN
        for (int g = 0; g < NWE; g++) begin
            cap_s[g*WORDSIZE +: WORDSIZE] =
                (bus.writeEnable[g] && (bus.writeAddr == bus.readAddr))
                    ? bus.writeData[g*WORDSIZE +: WORDSIZE]
                    : mem_q[bus.readAddr][g*WORDSIZE +: WORDSIZE];
        end
`endif
        pipe_d[0] = cap_s;
        for (int i = 1; i <= DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Read pipeline; reset discards in-flight reads but never touches the array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= DELAY; i++) begin
                pipe_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i <= DELAY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.readData = pipe_q[DELAY];
endmodule

// File: tb/tb_sram.sv
// Bench for sram: three instances (512/64 wide, 64-bit shallow, 64-bit deep)
// checked every cycle against a behavioural memory-plus-latency model.
module tb_sram;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sram_if #(.WIDTH(512), .LOGDEPTH(9),  .WORDSIZE(64)) i_wide  ();
    sram_if #(.WIDTH(64),  .LOGDEPTH(9),  .WORDSIZE(64)) i_small ();
    sram_if #(.WIDTH(64),  .LOGDEPTH(11), .WORDSIZE(64)) i_deep  ();

    sram #(.WIDTH(512), .LOGDEPTH(9),  .WORDSIZE(64)) u_wide  (.clk(clk), .reset_n(reset_n), .bus(i_wide));
    sram #(.WIDTH(64),  .LOGDEPTH(9),  .WORDSIZE(64)) u_small (.clk(clk), .reset_n(reset_n), .bus(i_small));
    sram #(.WIDTH(64),  .LOGDEPTH(11), .WORDSIZE(64)) u_deep  (.clk(clk), .reset_n(reset_n), .bus(i_deep));

    // Per-instance facts taken straight from the parameter rules.
    localparam int       NW   [3] = '{8, 1, 1};
    localparam int       LAT  [3] = '{1, 1, 3};
    localparam bit [7:0] FULL [3] = '{8'hFF, 8'h01, 8'h01};

    int vectors = 0;
    int errors  = 0;

    logic [511:0] mm   [3][2048];
    bit   [7:0]   wm   [3][2048];
    logic [511:0] ev   [3][3];
    bit           eok  [3][3];
    logic [511:0] s_wd [3];
    logic [10:0]  s_ra [3];
    logic [10:0]  s_wa [3];
    logic [7:0]   s_we [3];
    logic [511:0] cap;
    bit   [7:0]   capm;
    logic [511:0] act  [3];
    bit           bad;

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 3; k++) begin
                eok[d][k] = 1'b0;
                ev[d][k]  = 512'b0;
            end
        end
    end

    // Model: each edge the read value enters a delay line of LAT entries, then writes land.
    always @(posedge clk) begin
        s_ra[0] = {2'b0, i_wide.readAddr};  s_wa[0] = {2'b0, i_wide.writeAddr};
        s_wd[0] = i_wide.writeData;         s_we[0] = i_wide.writeEnable;
        s_ra[1] = {2'b0, i_small.readAddr}; s_wa[1] = {2'b0, i_small.writeAddr};
        s_wd[1] = {448'b0, i_small.writeData}; s_we[1] = {7'b0, i_small.writeEnable};
        s_ra[2] = i_deep.readAddr;          s_wa[2] = i_deep.writeAddr;
        s_wd[2] = {448'b0, i_deep.writeData};  s_we[2] = {7'b0, i_deep.writeEnable};
        for (int d = 0; d < 3; d++) begin
            if (!reset_n) begin
                for (int k = 0; k < 3; k++) begin
                    ev[d][k] = 512'b0; eok[d][k] = 1'b1;
                end
            end else begin
                cap  = mm[d][s_ra[d]];
                capm = wm[d][s_ra[d]];
`ifdef SRAM_WR_BYPASS_EN
                if (s_wa[d] == s_ra[d]) begin
                    for (int g = 0; g < NW[d]; g++)
                        if (s_we[d][g]) cap[g*64 +: 64] = s_wd[d][g*64 +: 64];
                    capm = capm | s_we[d];
                end
`endif
                for (int k = 2; k > 0; k--) begin
                    ev[d][k] = ev[d][k-1]; eok[d][k] = eok[d][k-1];
                end
                ev[d][0]  = cap;
                eok[d][0] = ((capm & FULL[d]) == FULL[d]);
                for (int g = 0; g < NW[d]; g++)
                    if (s_we[d][g]) mm[d][s_wa[d]][g*64 +: 64] = s_wd[d][g*64 +: 64];
                wm[d][s_wa[d]] = wm[d][s_wa[d]] | (s_we[d] & FULL[d]);
            end
        end
    end

    // Reset assertion empties the whole delay line at once.
    always @(negedge reset_n) begin
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 3; k++) begin
                ev[d][k] = 512'b0; eok[d][k] = 1'b1;
            end
    end

    // Compare every meaningful output on the falling edge.
    always @(negedge clk) begin
        act[0] = i_wide.readData;
        act[1] = {448'b0, i_small.readData};
        act[2] = {448'b0, i_deep.readData};
        for (int d = 0; d < 3; d++) begin
            if (eok[d][LAT[d]-1]) begin
                bad = 1'b0;
                for (int g = 0; g < NW[d]; g++)
                    if (act[d][g*64 +: 64] !== ev[d][LAT[d]-1][g*64 +: 64]) bad = 1'b1;
                vectors++;
                if (bad) begin
                    errors++;
                    $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h", d, $time, act[d], ev[d][LAT[d]-1]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [511:0] row;
    logic [511:0] rows [3];

    initial begin
        i_wide.readAddr  = 9'd0;  i_wide.writeAddr  = 9'd0;  i_wide.writeData  = 512'b0; i_wide.writeEnable  = 8'h00;
        i_small.readAddr = 9'd0;  i_small.writeAddr = 9'd0;  i_small.writeData = 64'b0;  i_small.writeEnable = 1'b0;
        i_deep.readAddr  = 11'd0; i_deep.writeAddr  = 11'd0; i_deep.writeData  = 64'b0;  i_deep.writeEnable  = 1'b0;
        tick(); tick();
        chk("rst_wide",  i_wide.readData, 512'b0);
        chk("rst_small", {448'b0, i_small.readData}, 512'b0);
        chk("rst_deep",  {448'b0, i_deep.readData}, 512'b0);
        reset_n = 1'b1;

        // Small instance: write row 5, read it, then reset mid-read.
        i_small.writeAddr = 9'd5; i_small.writeData = 64'hA5; i_small.writeEnable = 1'b1;
        tick();
        i_small.writeEnable = 1'b0; i_small.readAddr = 9'd5;
        tick();
        chk("small_rd5", {448'b0, i_small.readData}, {448'b0, 64'hA5});
        tick();
        #2 reset_n = 1'b0;
        #1 chk("rst_async", {448'b0, i_small.readData}, 512'b0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_rd5", {448'b0, i_small.readData}, {448'b0, 64'hA5});

        // Wide instance: full-row then partial write of row 3.
        for (int i = 0; i < 8; i++) row[i*64 +: 64] = 64'h1000 + 64'(i);
        i_wide.writeAddr = 9'd3; i_wide.writeData = row; i_wide.writeEnable = 8'hFF;
        tick();
        i_wide.writeData = {8{64'hFFFF_FFFF_FFFF_FFFF}};
        i_wide.writeData[128 +: 64] = 64'hDEAD;
        i_wide.writeEnable = 8'h04;
        tick();
        i_wide.writeEnable = 8'h00; i_wide.readAddr = 9'd3;
        tick();
        row[128 +: 64] = 64'hDEAD;
        chk("partial_row3", i_wide.readData, row);
        chk("partial_w2", {448'b0, i_wide.readData[128 +: 64]}, {448'b0, 64'hDEAD});
        chk("partial_w5", {448'b0, i_wide.readData[320 +: 64]}, {448'b0, 64'h1005});

        // Back-to-back reads of rows 0..2.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) rows[r][i*64 +: 64] = 64'h2000 + 64'(r * 16 + i);
            i_wide.writeAddr = 9'(r); i_wide.writeData = rows[r]; i_wide.writeEnable = 8'hFF;
            tick();
        end
        i_wide.writeEnable = 8'h00;
        for (int r = 0; r < 3; r++) begin
            i_wide.readAddr = 9'(r);
            tick();
            chk($sformatf("b2b_row%0d", r), i_wide.readData, rows[r]);
        end

        // Read-during-write on row 7.
        i_wide.writeAddr = 9'd7; i_wide.writeData = {8{64'h1}}; i_wide.writeEnable = 8'hFF;
        tick();
        i_wide.writeData = {8{64'h2}}; i_wide.readAddr = 9'd7;
        tick();
`ifdef SRAM_WR_BYPASS_EN
        chk("rdw_full", i_wide.readData, {8{64'h2}});
`else
        chk("rdw_full", i_wide.readData, {8{64'h1}});
`endif
        i_wide.writeEnable = 8'h00;
        tick();
        chk("rdw_after", i_wide.readData, {8{64'h2}});
        i_wide.writeData = {8{64'h3}}; i_wide.writeEnable = 8'h01;
        tick();
`ifdef SRAM_WR_BYPASS_EN
        chk("rdw_part", i_wide.readData, {{7{64'h2}}, 64'h3});
`else
        chk("rdw_part", i_wide.readData, {8{64'h2}});
`endif
        i_wide.writeAddr = 9'd9; i_wide.writeData = {8{64'h9}}; i_wide.writeEnable = 8'hFF;
        tick();
        chk("diff_addr", i_wide.readData, {{7{64'h2}}, 64'h3});
        i_wide.writeEnable = 8'h00;

        // Deep instance: three-edge latency.
        i_deep.writeAddr = 11'd0; i_deep.writeData = 64'h5555; i_deep.writeEnable = 1'b1;
        tick();
        i_deep.writeAddr = 11'd1500; i_deep.writeData = 64'hC0FFEE;
        tick();
        i_deep.writeEnable = 1'b0;
        tick(); tick(); tick();
        i_deep.readAddr = 11'd1500;
        tick();
        i_deep.readAddr = 11'd0;
        chk("lat_e1", {448'b0, i_deep.readData}, {448'b0, 64'h5555});
        tick();
        chk("lat_e2", {448'b0, i_deep.readData}, {448'b0, 64'h5555});
        tick();
        chk("lat_e3", {448'b0, i_deep.readData}, {448'b0, 64'hC0FFEE});
        tick();
        chk("lat_e4", {448'b0, i_deep.readData}, {448'b0, 64'h5555});

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sram.md
Name: sram

Overview:
- Synchronous, single-clock, one-read-port / one-write-port SRAM macro model with per-granule write enables.
- Used by the L1 caches twice per cache:
  - data array: line = 8 x 64-bit words, one enable bit per word;
  - tag array: granule = full width, one enable bit.
- Read data is registered, plus an optional depth-dependent pipeline delay that consumers wait out.

Parameters:
- WIDTH, 64: data width of one row in bits; must be an integer multiple of WORDSIZE.
- LOGDEPTH, 9: log2 of the number of rows (depth = 1<<LOGDEPTH).
- WORDSIZE, 64: write granule width in bits.
  - NWE = WIDTH/WORDSIZE write-enable bits.
  - Instantiating with WORDSIZE = WIDTH gives a single whole-row enable.
- DELAY, (LOGDEPTH>8 ? LOGDEPTH-8 : 1) - 1: extra read pipeline stages beyond the mandatory output register.
  - Matches the consumer's wait-counter formula for a single port.
  - 0 for LOGDEPTH <= 9.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- readAddr  in  LOGDEPTH  row to read.
- readData  out  WIDTH  registered read data.
- writeAddr  in  LOGDEPTH  row to write.
- writeData  in  WIDTH  write data; granule i is bits [i*WORDSIZE +: WORDSIZE].
- writeEnable  in  NWE  per-granule write enable; bit i gates granule i.

Behaviour:
- Storage: array of 1<<LOGDEPTH rows of WIDTH bits.
  - Contents are not cleared by reset and are X/undefined until written.
  - Consumers track validity themselves.
- Reset:
  - While reset_n = 0, readData and all internal read-pipeline registers are forced to 0, asynchronously on assertion.
  - Writes are suppressed while reset_n = 0.
  - Reset mid-operation discards in-flight reads; the array keeps its contents.
- Write:
  - At each posedge with reset_n = 1, for every i with writeEnable[i] = 1: row[writeAddr] granule i <= writeData granule i.
  - Granules with enable = 0 keep their old value.
  - writeEnable = 0 means no write.
  - There is no separate write strobe; the enables are the strobe.
- Read:
  - readAddr is sampled at every posedge; there is no read-enable.
  - The row contents land in readData after 1 + DELAY rising edges.
  - Fully pipelined: a new address can be issued every cycle, and results emerge in issue order.
  - readData holds its value between updates only insofar as readAddr is held; it is continuously re-read each cycle.
  - DELAY = 0: readData at edge N+1 = row[readAddr sampled at edge N].
- Read-during-write:
  - Same address, same edge: default is read-first. readData returns the pre-write contents for all granules.
  - Different addresses: independent, no interaction.
- Address width is exactly LOGDEPTH, so no out-of-range case exists.
- Elaboration check: if WIDTH % WORDSIZE != 0, a fatal error is raised at elaboration.
- Synthesis intent: inferable as block RAM with byte/granule enables.
  - Behavioural $display of the configuration at time 0 is permitted.

Optional Feature:
- Macro: SRAM_WR_BYPASS_EN.
- Defined: on a same-address read-during-write, each granule whose writeEnable bit is 1 returns the new writeData granule. Granules with enable 0 return the old contents (write-first per granule).
- Undefined: read-first behaviour as above.
- The feature affects only the first pipeline stage's captured value, so latency is unchanged.

Test Plan:
- Reset: assert reset_n = 0 mid-read -> readData = 0 immediately. Deassert, read row 5 previously written 64'hA5 (WIDTH=64, WORDSIZE=64) -> readData = 64'hA5 one edge after the address is applied.
- Full-row write: WIDTH=512, WORDSIZE=64, write row 3 with writeEnable = 8'hFF and words 0..7 = 64'h1000+i -> reading row 3 returns all eight words.
- Partial write: then write row 3 with writeEnable = 8'h04 and writeData word 2 = 64'hDEAD -> word 2 = 64'hDEAD, other words unchanged (64'h1000+i).
- Back-to-back reads: rows 0, 1, 2 on consecutive cycles holding distinct data -> readData sequence matches with 1-cycle latency and no bubbles.
- Read-during-write on row 7 (old 64'h1, new 64'h2): without the macro -> readData = 64'h1, then 64'h2 on the next read. With SRAM_WR_BYPASS_EN -> readData = 64'h2 immediately.
- Latency check: LOGDEPTH = 11 (DELAY = 2) -> data appears 3 edges after the address.
